// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared compare modes and sizing helper for the comparator array
package comparator_pkg;

    localparam logic [1:0] CMP_EQ  = 2'd0;
    localparam logic [1:0] CMP_GT  = 2'd1;
    localparam logic [1:0] CMP_LT  = 2'd2;
    localparam logic [1:0] CMP_MAX = 2'd3;

    // Width able to hold a popcount of 0..num_ch inclusive.
    function automatic int cnt_width(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/comparator_lane.sv
// rtl/comparator_lane.sv - combinational single-lane compare with mask/select result
module comparator_lane
    import comparator_pkg::*;
#(
    parameter int LANE_W = 2,
    parameter int SIGNED = 0
) (
    input  logic [LANE_W-1:0] sample,
    input  logic [LANE_W-1:0] reference,
    input  logic [1:0]        mode,
    output logic              match,
    output logic [LANE_W-1:0] result
);

    logic eq;
    logic gt;
    logic lt;

    always_comb begin
        eq = (sample == reference);
        if (SIGNED != 0) begin
            gt = ($signed(sample) > $signed(reference));
            lt = ($signed(sample) < $signed(reference));
        end else begin
            gt = (sample > reference);
            lt = (sample < reference);
        end

        // MAX shares the GT predicate; only its non-match output differs.
        case (mode)
            CMP_EQ:  match = eq;
            CMP_GT:  match = gt;
            CMP_LT:  match = lt;
            default: match = gt;
        endcase

        if (match) begin
            result = sample;
        end else if (mode == CMP_MAX) begin
            result = reference;
        end else begin
            result = '0;
        end
    end

endmodule

// File: rtl/comparator_array.sv
// rtl/comparator_array.sv - pipelined lane-wise comparator array with ping-pong reference bank
module comparator_array
    import comparator_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int LANE_W = 2,
    parameter int SIGNED = 0,
    parameter int CNT_W  = cnt_width(NUM_CH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_CH*LANE_W-1:0] D_IN,
    input  logic                     D_EN,
    input  logic                     SWITCH,
    input  logic                     COMPARE_EN,
    input  logic [1:0]               COMPARE_MODE,
    output logic                     IN_READY,
    output logic [NUM_CH*LANE_W-1:0] D_OUT,
    output logic [NUM_CH-1:0]        MATCH_VEC,
    output logic [CNT_W-1:0]         MATCH_CNT,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY
);

    localparam int W = NUM_CH * LANE_W;

    logic [W-1:0]      ref0;
    logic [W-1:0]      ref1;
    logic              act;
    logic [W-1:0]      act_ref;
    logic              adv;
    logic              accept;
    logic [W-1:0]      lane_out;
    logic [NUM_CH-1:0] lane_match;
    logic              s1_valid;
    logic [W-1:0]      s1_out;
    logic [NUM_CH-1:0] s1_match;
    logic [CNT_W-1:0]  pop;

    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv && !RST;
    // The data bus is shared, so a bank load wins over a compare in the same cycle.
    assign accept   = COMPARE_EN && IN_READY && !D_EN;
    assign act_ref  = act ? ref1 : ref0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        comparator_lane #(
            .LANE_W (LANE_W),
            .SIGNED (SIGNED)
        ) u_lane (
            .sample    (D_IN[i*LANE_W +: LANE_W]),
            .reference (act_ref[i*LANE_W +: LANE_W]),
            .mode      (COMPARE_MODE),
            .match     (lane_match[i]),
            .result    (lane_out[i*LANE_W +: LANE_W])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + CNT_W'(s1_match[i]);
        end
    end

    // Writes target the shadow bank as seen before any same-edge swap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ref0 <= '0;
            ref1 <= '0;
            act  <= 1'b0;
        end else begin
            if (D_EN) begin
                if (act) begin
                    ref0 <= D_IN;
                end else begin
                    ref1 <= D_IN;
                end
            end
            if (SWITCH) begin
                act <= !act;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s1_out    <= '0;
            s1_match  <= '0;
            OUT_VALID <= 1'b0;
            D_OUT     <= '0;
            MATCH_VEC <= '0;
            MATCH_CNT <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_out   <= lane_out;
                s1_match <= lane_match;
            end
            OUT_VALID <= s1_valid;
            if (s1_valid) begin
                D_OUT     <= s1_out;
                MATCH_VEC <= s1_match;
                MATCH_CNT <= pop;
            end
        end
    end

endmodule

// File: tb/tb_comparator_array.sv
// tb/tb_comparator_array.sv - directed self-checking bench for comparator_array
module tb_comparator_array;
    import comparator_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] m;
        logic [2:0] c;
    } beat_t;

    typedef struct {
        int    idx;
        beat_t b;
        logic  rdy;
    } stall_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] D_IN;
    logic       D_EN;
    logic       SWITCH;
    logic       COMPARE_EN;
    logic [1:0] COMPARE_MODE;
    logic       OUT_READY;

    logic       IN_READY;
    logic [7:0] D_OUT;
    logic [3:0] MATCH_VEC;
    logic [2:0] MATCH_CNT;
    logic       OUT_VALID;

    logic       s_in_ready;
    logic [7:0] s_dout;
    logic [3:0] s_match;
    logic [2:0] s_cnt;
    logic       s_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall_from = -100;

    beat_t  exp_q[$];
    beat_t  obs[$];
    stall_t stalls[$];

    always #5 CLK = ~CLK;

    comparator_array #(.NUM_CH(4), .LANE_W(2), .SIGNED(0)) dut_u (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .D_EN(D_EN), .SWITCH(SWITCH),
        .COMPARE_EN(COMPARE_EN), .COMPARE_MODE(COMPARE_MODE), .IN_READY(IN_READY),
        .D_OUT(D_OUT), .MATCH_VEC(MATCH_VEC), .MATCH_CNT(MATCH_CNT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    comparator_array #(.NUM_CH(4), .LANE_W(2), .SIGNED(1)) dut_s (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .D_EN(D_EN), .SWITCH(SWITCH),
        .COMPARE_EN(COMPARE_EN), .COMPARE_MODE(COMPARE_MODE), .IN_READY(s_in_ready),
        .D_OUT(s_dout), .MATCH_VEC(s_match), .MATCH_CNT(s_cnt),
        .OUT_VALID(s_valid), .OUT_READY(OUT_READY)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        D_EN = 1'b1;
        D_IN = d;
        tick();
        D_EN   = 1'b0;
        SWITCH = 1'b1;
        tick();
        SWITCH = 1'b0;
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] d, input logic sw);
        logic ok;
        ok = 1'b0;
        COMPARE_EN   = 1'b1;
        COMPARE_MODE = m;
        D_IN         = d;
        SWITCH       = sw;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge CLK);
            ok = IN_READY;
            @(posedge CLK);
            #1;
            SWITCH = 1'b0;
        end
        COMPARE_EN = 1'b0;
        if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    // Downstream ready: high except for a 3-cycle window requested by the main sequence.
    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            OUT_READY = !(cyc >= stall_from && cyc < stall_from + 3);
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (OUT_VALID && OUT_READY) begin
                obs.push_back('{D_OUT, MATCH_VEC, MATCH_CNT});
            end else if (OUT_VALID) begin
                stalls.push_back('{obs.size(), '{D_OUT, MATCH_VEC, MATCH_CNT}, IN_READY});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; D_IN = '0; D_EN = 1'b0; SWITCH = 1'b0;
        COMPARE_EN = 1'b0; COMPARE_MODE = CMP_EQ;
        repeat (3) tick();
        @(negedge CLK);
        check_eq("rst_valid", OUT_VALID, 0);
        check_eq("rst_dout", D_OUT, 0);
        check_eq("rst_vec", MATCH_VEC, 0);
        check_eq("rst_cnt", MATCH_CNT, 0);
        check_eq("rst_in_ready", IN_READY, 0);
        tick();
        RST = 1'b0;
        tick();

        // EQ against a freshly loaded and switched bank, with latency check
        load(8'b10_01_11_00);
        exp_q.push_back('{8'b10_00_11_00, 4'b1010, 3'd2});
        send(CMP_EQ, 8'b10_00_11_01, 1'b0);
        @(negedge CLK);
        check_eq("lat_s1_only", OUT_VALID, 0);
        @(negedge CLK);
        check_eq("lat_valid", OUT_VALID, 1);
        tick();

        // ref = 01 in every lane
        load(8'h55);
        exp_q.push_back('{8'b11_01_01_10, 4'b1001, 3'd2});
        send(CMP_MAX, 8'b11_00_01_10, 1'b0);
        exp_q.push_back('{8'b11_00_00_10, 4'b1001, 3'd2});
        send(CMP_GT, 8'b11_00_01_10, 1'b0);
        exp_q.push_back('{8'h00, 4'b1010, 3'd2});
        send(CMP_LT, 8'b00_10_00_01, 1'b0);
        exp_q.push_back('{8'h50, 4'b1100, 3'd2});
        send(CMP_EQ, 8'h5A, 1'b0);
        repeat (3) tick();

        // ref = 11 in every lane: -1 when signed, 3 when unsigned
        load(8'hFF);
        exp_q.push_back('{8'h00, 4'b0000, 3'd0});
        send(CMP_GT, 8'h00, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        check_eq("signed_valid", s_valid, 1);
        check_eq("signed_vec", s_match, 4'b1111);
        check_eq("signed_cnt", s_cnt, 4);
        check_eq("signed_dout", s_dout, 8'h00);
        tick();

        // Ping-pong: compare+switch uses the old bank, load+switch activates the new data
        D_EN = 1'b1; D_IN = 8'h1B;
        tick();
        D_EN = 1'b0;
        exp_q.push_back('{8'hFF, 4'b1111, 3'd4});
        send(CMP_EQ, 8'hFF, 1'b1);
        exp_q.push_back('{8'h1B, 4'b1111, 3'd4});
        send(CMP_EQ, 8'h1B, 1'b0);
        D_EN = 1'b1; SWITCH = 1'b1; COMPARE_EN = 1'b1; COMPARE_MODE = CMP_EQ; D_IN = 8'hE4;
        tick();
        D_EN = 1'b0; SWITCH = 1'b0; COMPARE_EN = 1'b0;
        exp_q.push_back('{8'hE4, 4'b1111, 3'd4});
        send(CMP_EQ, 8'hE4, 1'b0);
        exp_q.push_back('{8'h00, 4'b0000, 3'd0});
        send(CMP_EQ, 8'h1B, 1'b0);
        repeat (3) tick();

        // Back-pressure: 5 beats against E4 with a 3-cycle stall mid-stream
        stall_from = cyc + 3;
        exp_q.push_back('{8'hE4, 4'b1111, 3'd4});
        send(CMP_EQ, 8'hE4, 1'b0);
        exp_q.push_back('{8'hE0, 4'b1101, 3'd3});
        send(CMP_EQ, 8'hE0, 1'b0);
        exp_q.push_back('{8'h24, 4'b0111, 3'd3});
        send(CMP_EQ, 8'h24, 1'b0);
        exp_q.push_back('{8'h00, 4'b0001, 3'd1});
        send(CMP_EQ, 8'h00, 1'b0);
        exp_q.push_back('{8'h24, 4'b0111, 3'd3});
        send(CMP_EQ, 8'hA4, 1'b0);
        repeat (6) tick();

        // Reset with two beats in flight: the first escapes before reset, the second is lost
        exp_q.push_back('{8'hE4, 4'b1111, 3'd4});
        send(CMP_EQ, 8'hE4, 1'b0);
        send(CMP_EQ, 8'h1B, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        check_eq("rst_mid_in_ready", IN_READY, 0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rst_flush", OUT_VALID, 0);
        repeat (3) begin
            @(negedge CLK);
            check_eq("no_stale", OUT_VALID, 0);
        end
        tick();
        exp_q.push_back('{8'h00, 4'b1111, 3'd4});
        send(CMP_EQ, 8'h00, 1'b0);
        repeat (6) tick();

        check_eq("beat_count", obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("beat%0d_dout", i), obs[i].d, exp_q[i].d);
            check_eq($sformatf("beat%0d_vec", i), obs[i].m, exp_q[i].m);
            check_eq($sformatf("beat%0d_cnt", i), obs[i].c, exp_q[i].c);
        end
        check_eq("stall_seen", stalls.size() != 0, 1);
        for (int i = 0; i < stalls.size(); i++) begin
            check_eq($sformatf("stall%0d_in_ready", i), stalls[i].rdy, 0);
            if (stalls[i].idx < exp_q.size()) begin
                check_eq($sformatf("stall%0d_hold", i), stalls[i].b, exp_q[stalls[i].idx]);
            end else begin
                check_eq($sformatf("stall%0d_idx", i), stalls[i].idx, exp_q.size() - 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
